mac_share_arbiter: RTL and testbench
====================================

# mac_share_arbiter

Round-robin controller that time-shares one fixed-function 256x256 multiplier between NREQ requesters. Each requester holds a private accumulator inside this block. The block accepts one operand pair at a time through a valid/ready handshake, sequences the shared multiplier with a start pulse, and waits for its done strobe. It then adds the product into the granted requester's accumulator and returns the updated sum on a shared response bus. It sits between the job sources and the multiplier core of the MAC512 datapath.

## Interface
- OP_W, 256, operand width.
- ACC_W, 512, accumulator width; must be >= 2*OP_W.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester index; must satisfy 2^IDW >= NREQ.
- MUL_TIMEOUT, 300, WAIT-state cycle limit. Used only with MAC_ARB_TIMEOUT_EN.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester job valid.
- req_clr  in  NREQ  per-requester "zero accumulator before adding" flag, sampled with the job.
- req_a  in  NREQ*OP_W  packed operand A; requester i occupies bits [i*OP_W +: OP_W].
- req_b  in  NREQ*OP_W  packed operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot acceptance strobe.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  OP_W  operand A to the multiplier.
- mul_b  out  OP_W  operand B to the multiplier.
- mul_done  in  1  multiplier completion strobe.
- mul_prod  in  2*OP_W  multiplier product, valid when mul_done=1.
- resp_valid  out  1  one-cycle response pulse.
- resp_id  out  IDW  index of the responding requester.
- resp_acc  out  ACC_W  updated accumulator value.
- resp_err  out  1  timeout flag. Present only with MAC_ARB_TIMEOUT_EN.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, START, WAIT, ACC, RESP.
- IDLE:
  - Select the first requester with req_valid=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - Drive req_ready[g]=1 combinationally in the same cycle. req_ready is 0 in all other states.
  - On that edge: latch req_a, req_b and req_clr of g into op_a, op_b and clr_q; set id_q=g; set rr_ptr=(g+1) mod NREQ; go to START.
- START: mul_start=1 for exactly one cycle, then go to WAIT. Any mul_done seen in START is ignored.
- WAIT:
  - mul_a=op_a and mul_b=op_b are held stable from START until the block leaves WAIT.
  - On mul_done=1: register mul_prod and go to ACC.
- ACC:
  - acc[id_q] <= (clr_q ? 0 : acc[id_q]) + zero-extended product, truncated modulo 2^ACC_W.
  - Overflow wraps silently.
  - Go to RESP.
- RESP: resp_valid=1, resp_id=id_q, resp_acc=acc[id_q]. Go to IDLE.
- Requesters must hold req_valid and their operands stable until they see req_ready. The result of dropping req_valid early is undefined for that requester; arbitration of the others is unaffected.
- Requesters not granted are never starved: the maximum wait is (NREQ-1) jobs.
- Reset:
  - Values: state=IDLE, rr_ptr=0, all acc[i]=0, op_a=0, op_b=0, clr_q=0, id_q=0.
  - Every output is 0, including resp_err.
  - Reset asserted mid-job abandons the job with no response. The multiplier shares rst.

## Timing
- Let T be the acceptance cycle (IDLE with req_ready[g]=1).
- mul_start=1 at cycle T+1.
- If the multiplier asserts mul_done at T+1+D (D>=1), resp_valid=1 at T+D+3.
- The block is back in IDLE at T+D+4, and the next acceptance can happen in that cycle.
- Minimum job-to-job spacing is D+4 cycles.
- resp_acc, resp_id and resp_valid are all registered and are all 0 outside RESP.

## Configuration
- MAC_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT. It clears on entry to WAIT and counts 1, 2, 3, ...
  - If it reaches MUL_TIMEOUT without mul_done, the FSM goes straight to RESP. The accumulator is unchanged, resp_acc shows the old acc[id_q], and resp_err=1 for that pulse.
  - resp_err=0 on every normal response.
- MAC_ARB_TIMEOUT_EN undefined: no counter and no resp_err port. WAIT waits indefinitely.

## Test plan
- Single job: req0 with a=3, b=5, clr=1; multiplier model D=4. Required: mul_start at T+1, resp_valid at T+7 with resp_id=0 and resp_acc=15.
- Accumulate: req2 issues (2,7,clr=1), then (4,4,clr=0), then (1,1,clr=0). Required: resp_acc sequence 14, 30, 31.
- Round-robin: all four req_valid held high for 8 jobs. Required: grant order 0,1,2,3,0,1,2,3.
- Wrap: req1 issues a=b=2^256-1 twice with clr=0 from reset. Required: second resp_acc equals 2*(2^256-1)^2 mod 2^512.
- Reset mid-job: assert rst in WAIT. Required: no resp_valid, all outputs 0, and the next req0 job (1,1,clr=0) returns resp_acc=1.
- Timeout (macro on, MUL_TIMEOUT=10): mul_done never asserted. Required: resp_valid with resp_err=1 exactly 12 cycles after mul_start, and the accumulator unchanged.

Source files
------------

// File: rtl/mac_share_arbiter_if.sv
// Requester, multiplier and response bus of mac_share_arbiter.
// resp_err exists only when MAC_ARB_TIMEOUT_EN is defined.
interface mac_share_arbiter_if #(
  parameter int OP_W  = 256,
  parameter int ACC_W = 512,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_clr;
  logic [NREQ*OP_W-1:0] req_a;
  logic [NREQ*OP_W-1:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 mul_start;
  logic [OP_W-1:0]      mul_a;
  logic [OP_W-1:0]      mul_b;
  logic                 mul_done;
  logic [2*OP_W-1:0]    mul_prod;
  logic                 resp_valid;
  logic [IDW-1:0]       resp_id;
  logic [ACC_W-1:0]     resp_acc;
`ifdef MAC_ARB_TIMEOUT_EN
  logic                 resp_err;
`endif
  logic                 busy;

  modport slave (
`ifdef MAC_ARB_TIMEOUT_EN
    output resp_err,
`endif
    input  req_valid, req_clr, req_a, req_b,
    output req_ready,
    output mul_start, mul_a, mul_b,
    input  mul_done, mul_prod,
    output resp_valid, resp_id, resp_acc, busy
  );

  modport master (
`ifdef MAC_ARB_TIMEOUT_EN
    input  resp_err,
`endif
    output req_valid, req_clr, req_a, req_b,
    input  req_ready,
    input  mul_start, mul_a, mul_b,
    output mul_done, mul_prod,
    input  resp_valid, resp_id, resp_acc, busy
  );
endinterface

// File: rtl/mac_share_arbiter.sv
// Round-robin sharing of one multiplier with per-requester accumulators.
// MAC_ARB_TIMEOUT_EN adds a WAIT-state watchdog and resp_err.
module mac_share_arbiter #(
  parameter int OP_W  = 256,
  parameter int ACC_W = 512,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
`ifdef MAC_ARB_TIMEOUT_EN
  ,
  parameter int MUL_TIMEOUT = 300
`endif
) (
  input  logic               clk,
  input  logic               rst,
  mac_share_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, START, WAIT, ACC, RESP
  } state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [OP_W-1:0]   opa_q, opa_d;
  logic [OP_W-1:0]   opb_q, opb_d;
  logic              clr_q, clr_d;
  logic [2*OP_W-1:0] prod_q, prod_d;
  logic [ACC_W-1:0]  acc_q [NREQ];
  logic [ACC_W-1:0]  acc_d [NREQ];
  logic              rv_q, rv_d;
  logic [IDW-1:0]    rid_q, rid_d;
  logic [ACC_W-1:0]  racc_q, racc_d;

`ifdef MAC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(MUL_TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  logic            found;
  logic [IDW-1:0]  gnt;
  logic [IDW:0]    cand;
  logic [IDW:0]    nxt;
  logic [OP_W-1:0] sel_a, sel_b;
  logic            sel_clr;
  logic [NREQ-1:0] ready;
  logic [ACC_W-1:0] acc_cur, acc_sum;

  // first valid requester at or above rr_q, wrapping
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ))
        cand = cand - (IDW+1)'(NREQ);
      if (!found && bus.req_valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        gnt   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_clr = 1'b0;
    ready   = '0;
    acc_cur = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IDW'(i)) begin
        sel_a   = bus.req_a[i*OP_W +: OP_W];
        sel_b   = bus.req_b[i*OP_W +: OP_W];
        sel_clr = bus.req_clr[i];
        ready[i] = found && (state_q == IDLE) && !rst;
      end
      if (id_q == IDW'(i))
        acc_cur = acc_q[i];
    end
    nxt = {1'b0, gnt} + 1'b1;
    if (nxt == (IDW+1)'(NREQ))
      nxt = '0;
    acc_sum = (clr_q ? '0 : acc_cur) + ACC_W'(prod_q);
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    clr_d   = clr_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    rv_d    = 1'b0;
    rid_d   = '0;
    racc_d  = '0;
`ifdef MAC_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          opa_d   = sel_a;
          opb_d   = sel_b;
          clr_d   = sel_clr;
          id_d    = gnt;
          rr_d    = nxt[IDW-1:0];
          state_d = START;
        end
      end
      START: begin
`ifdef MAC_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.mul_done) begin
          prod_d  = bus.mul_prod;
          state_d = ACC;
        end
`ifdef MAC_ARB_TIMEOUT_EN
        // give up: old accumulator is reported with resp_err
        else if (cnt_q == TW'(MUL_TIMEOUT)) begin
          rv_d    = 1'b1;
          rid_d   = id_q;
          racc_d  = acc_cur;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ACC: begin
        acc_d[id_q] = acc_sum;
        rv_d    = 1'b1;
        rid_d   = id_q;
        racc_d  = acc_sum;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      clr_q   <= 1'b0;
      prod_q  <= '0;
      rv_q    <= 1'b0;
      rid_q   <= '0;
      racc_q  <= '0;
      for (int i = 0; i < NREQ; i++)
        acc_q[i] <= '0;
`ifdef MAC_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      clr_q   <= clr_d;
      prod_q  <= prod_d;
      rv_q    <= rv_d;
      rid_q   <= rid_d;
      racc_q  <= racc_d;
      for (int i = 0; i < NREQ; i++)
        acc_q[i] <= acc_d[i];
`ifdef MAC_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.req_ready  = ready;
  assign bus.mul_start  = (state_q == START);
  assign bus.mul_a      = opa_q;
  assign bus.mul_b      = opb_q;
  assign bus.resp_valid = rv_q;
  assign bus.resp_id    = rid_q;
  assign bus.resp_acc   = racc_q;
  assign bus.busy       = (state_q != IDLE);
`ifdef MAC_ARB_TIMEOUT_EN
  assign bus.resp_err   = err_q;
`endif

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Randomized bench for mac_share_arbiter against a job-level model.
// Define MAC_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_mac_share_arbiter;
  localparam int OP_W  = 256;
  localparam int ACC_W = 512;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_share_arbiter_if #(
    .OP_W(OP_W), .ACC_W(ACC_W), .NREQ(NREQ), .IDW(IDW)
  ) bus ();

  mac_share_arbiter #(
    .OP_W(OP_W), .ACC_W(ACC_W), .NREQ(NREQ), .IDW(IDW)
`ifdef MAC_ARB_TIMEOUT_EN
    , .MUL_TIMEOUT(10)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [ACC_W-1:0] m_acc [NREQ];
  int               m_ptr;
  logic [OP_W-1:0]  va [NREQ];
  logic [OP_W-1:0]  vb [NREQ];
  logic [NREQ-1:0]  vclr;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [ACC_W-1:0] got,
                     input logic [ACC_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++)
      if (mask[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return 0;
  endfunction

  function automatic logic [OP_W-1:0] rnd_op();
    logic [OP_W-1:0] v;
    v = '0;
    case ($urandom_range(0, 3))
      0: v = '1;
      1: v = OP_W'($urandom_range(0, 255));
      default:
        for (int i = 0; i < OP_W/32; i++) v[i*32 +: 32] = $urandom;
    endcase
    return v;
  endfunction

  function automatic logic [ACC_W-1:0] junk();
    logic [ACC_W-1:0] v;
    for (int i = 0; i < ACC_W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive(input logic [NREQ-1:0] mask);
    bus.req_valid = mask;
    bus.req_clr   = vclr;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*OP_W +: OP_W] = va[i];
      bus.req_b[i*OP_W +: OP_W] = vb[i];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) m_acc[i] = '0;
    m_ptr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(NREQ'($urandom_range(1, 15)));
    bus.mul_done = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_start", bus.mul_start, 0);
    chk("rst_rv", bus.resp_valid, 0);
    chk("rst_acc", bus.resp_acc, 0);
    chk("rst_mula", bus.mul_a, 0);
`ifdef MAC_ARB_TIMEOUT_EN
    chk("rst_err", bus.resp_err, 0);
`endif
    rst = 1'b0;
    bus.req_valid = '0;
    model_reset();
  endtask

  // one job from acceptance to response, multiplier latency d
  task automatic job(input logic [NREQ-1:0] mask, input int d);
    int g;
    logic [NREQ-1:0]  oh;
    logic [ACC_W-1:0] xa, xb, prod, exp;
    g = pick(mask);
    @(negedge clk);
    drive(mask);
    #1;
    oh = '0;
    oh[g] = 1'b1;
    chk("idle_rv", bus.resp_valid, 0);
    chk("req_ready", bus.req_ready, oh);
    xa   = va[g];
    xb   = vb[g];
    prod = xa * xb;
    exp  = (vclr[g] ? '0 : m_acc[g]) + prod;
    @(negedge clk);
    bus.req_valid = '0;
    chk("mul_start", bus.mul_start, 1);
    chk("mul_a", bus.mul_a, va[g]);
    chk("mul_b", bus.mul_b, vb[g]);
    bus.mul_done = 1'b1;
    bus.mul_prod = junk();
    for (int t = 1; t <= d; t++) begin
      @(negedge clk);
      chk("start_once", bus.mul_start, 0);
      bus.mul_done = (t == d);
      bus.mul_prod = (t == d) ? prod : junk();
    end
    chk("hold_a", bus.mul_a, va[g]);
    chk("hold_b", bus.mul_b, vb[g]);
    @(negedge clk);
    bus.mul_done = 1'b0;
    chk("rv_early", bus.resp_valid, 0);
    @(negedge clk);
    chk("rv", bus.resp_valid, 1);
    chk("rid", bus.resp_id, g);
    chk("racc", bus.resp_acc, exp);
`ifdef MAC_ARB_TIMEOUT_EN
    chk("rerr", bus.resp_err, 0);
`endif
    m_acc[g] = exp;
    m_ptr = (g + 1) % NREQ;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_clr   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.mul_done  = 1'b0;
    bus.mul_prod  = '0;
    for (int i = 0; i < NREQ; i++) begin
      va[i] = '0;
      vb[i] = '0;
    end
    vclr = '0;
    model_reset();
    do_reset();

    va[0] = 3; vb[0] = 5; vclr = 4'b0001;
    job(4'b0001, 4);

    va[2] = 2; vb[2] = 7; vclr = 4'b0100;
    job(4'b0100, 2);
    va[2] = 4; vb[2] = 4; vclr = '0;
    job(4'b0100, 1);
    va[2] = 1; vb[2] = 1;
    job(4'b0100, 3);

    do_reset();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        va[i] = rnd_op();
        vb[i] = rnd_op();
      end
      vclr = NREQ'($urandom);
      job(4'b1111, $urandom_range(1, 4));
    end

    do_reset();
    va[1] = '1; vb[1] = '1; vclr = '0;
    job(4'b0010, 2);
    job(4'b0010, 5);

    // reset while the multiplier is busy
    va[0] = rnd_op(); vb[0] = rnd_op();
    @(negedge clk);
    drive(4'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      chk("mid_rv", bus.resp_valid, 0);
      chk("mid_busy", bus.busy, 0);
      chk("mid_mula", bus.mul_a, 0);
      chk("mid_start", bus.mul_start, 0);
    end
    rst = 1'b0;
    model_reset();
    va[0] = 1; vb[0] = 1; vclr = '0;
    job(4'b0001, 3);

`ifdef MAC_ARB_TIMEOUT_EN
    begin
      int g;
      va[3] = rnd_op(); vb[3] = rnd_op();
      g = pick(4'b1000);
      @(negedge clk);
      drive(4'b1000);
      #1;
      chk("to_ready", bus.req_ready, 4'b1000);
      @(negedge clk);
      bus.req_valid = '0;
      chk("to_start", bus.mul_start, 1);
      for (int t = 1; t <= 11; t++) begin
        @(negedge clk);
        chk("to_early", bus.resp_valid, 0);
      end
      @(negedge clk);
      chk("to_rv", bus.resp_valid, 1);
      chk("to_err", bus.resp_err, 1);
      chk("to_id", bus.resp_id, g);
      chk("to_acc", bus.resp_acc, m_acc[g]);
      m_ptr = (g + 1) % NREQ;
    end
`endif

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        va[i] = rnd_op();
        vb[i] = rnd_op();
      end
      vclr = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
      job(NREQ'($urandom_range(1, 15)), $urandom_range(1, 6));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
